// File: rtl/stall_ctrl.sv
// stall_ctrl: hazard and stall controller for the five-stage pipeline.
//
// Each cycle it decides whether fetch advances, whether F/D holds, and
// whether a bubble enters D/E. Register hazards come from a Tuse/Tnew
// comparison against the instructions in E and M. A busy counter covers
// the multi-cycle multiply/divide window so that HI/LO users in D wait.
//
// Optional feature macro: STALL_CTRL_MD_EN
//   defined   - busy counter, md_busy and the MD stall are built.
//   undefined - no counter, md_busy tied low, MD inputs ignored.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   d_rs_addr, d_rt_addr   source register indices of the D instruction
//   d_rs_tuse, d_rt_tuse   cycles until D needs the source (3 = not read)
//   e_wa, e_tnew           destination / cycles-to-forwardable of E
//   m_wa, m_tnew           destination / cycles-to-forwardable of M
//   d_md_use               D holds a mult/div/HI/LO instruction
//   e_md_start, e_md_div   E starts a multiply (div=0) or divide (div=1)
//   pc_en, fd_en           PC and F/D register enables
//   de_flush               D/E register clears to a nop on the next edge
//   md_busy                multiply/divide unit occupied
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic [4:0] e_wa,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_wa,
  input  logic [1:0] m_tnew,
  input  logic       d_md_use,
  input  logic       e_md_start,
  input  logic       e_md_div,
  output logic       pc_en,
  output logic       fd_en,
  output logic       de_flush,
  output logic       md_busy
);

  logic stall_rs;
  logic stall_rt;
  logic md_stall;
  logic md_active;
  logic stall;

  // A source stalls when a producer in E or M writes it and its result
  // will not be forwardable before D needs it. $0 and unread sources
  // never stall.
  always_comb begin
    stall_rs = (d_rs_addr != 5'd0) && (d_rs_tuse != 2'd3) &&
               (((e_wa == d_rs_addr) && (e_tnew > d_rs_tuse)) ||
                ((m_wa == d_rs_addr) && (m_tnew > d_rs_tuse)));
    stall_rt = (d_rt_addr != 5'd0) && (d_rt_tuse != 2'd3) &&
               (((e_wa == d_rt_addr) && (e_tnew > d_rt_tuse)) ||
                ((m_wa == d_rt_addr) && (m_tnew > d_rt_tuse)));
  end

`ifdef STALL_CTRL_MD_EN
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W_RAW  = $clog2(MAX_CYCLES + 1);
  localparam int CNT_W      = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

  logic [CNT_W-1:0] cnt;

  // Busy counter: a start is only accepted when idle; a start while the
  // unit is still counting is dropped and the count keeps running down.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (e_md_start && (cnt == '0)) begin
      cnt <= e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // The starting instruction itself already blocks a HI/LO user in D,
  // before the counter has been loaded.
  assign md_active = (cnt != '0);
  assign md_stall  = d_md_use && (md_active || e_md_start);
`else
  logic md_inputs_unused;
  localparam int MD_CYCLES_UNUSED = MULT_CYCLES + DIV_CYCLES;

  assign md_inputs_unused = ^{d_md_use, e_md_start, e_md_div};
  assign md_active        = 1'b0;
  assign md_stall         = 1'b0;
`endif

  // While reset is high the hazard logic is masked so the pipeline
  // registers can clear themselves.
  always_comb begin
    stall    = 1'b0;
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    de_flush = 1'b0;
    md_busy  = 1'b0;
    if (!reset) begin
      stall    = stall_rs || stall_rt || md_stall;
      pc_en    = !stall;
      fd_en    = !stall;
      de_flush = stall;
      md_busy  = md_active;
    end
  end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Hazard and stall controller for the five-stage pipeline. It decides each cycle whether fetch advances (drives the PC register's `en`) and whether the F/D register holds. It also decides whether a bubble enters the D/E register. It compares Tuse/Tnew for register hazards and tracks a multi-cycle multiply/divide busy window so HI/LO users wait.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles after a mult/multu starts.
- `DIV_CYCLES`, 10: busy cycles after a div/divu starts.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `d_rs_addr`  in  5  rs index of the instruction in D.
- `d_rt_addr`  in  5  rt index of the instruction in D.
- `d_rs_tuse`  in  2  cycles until D needs rs (0..2); 3 = rs not read.
- `d_rt_tuse`  in  2  same for rt.
- `e_wa`  in  5  destination register of the instruction in E; 0 = none.
- `e_tnew`  in  2  cycles until E's result is forwardable (already adjusted for the E stage).
- `m_wa`  in  5  destination register of the instruction in M.
- `m_tnew`  in  2  same for M.
- `d_md_use`  in  1  D holds mult/div/mfhi/mflo/mthi/mtlo.
- `e_md_start`  in  1  E holds mult/multu/div/divu this cycle.
- `e_md_div`  in  1  qualifies `e_md_start`: 1 = divide, 0 = multiply.
- `pc_en`  out  1  PC register enable.
- `fd_en`  out  1  F/D register enable.
- `de_flush`  out  1  D/E register clears to a nop on the next edge.
- `md_busy`  out  1  multiply/divide unit occupied (registered count nonzero).

## Operation
- **Data hazard, per source s ∈ {rs, rt}**: `stall_s` = (addr_s ≠ 0) ∧ (tuse_s ≠ 3) ∧ [(e_wa = addr_s ∧ e_tnew > tuse_s) ∨ (m_wa = addr_s ∧ m_tnew > tuse_s)]. The comparison is unsigned, 2-bit.
- **MD hazard**: `md_stall` = d_md_use ∧ (md_busy ∨ e_md_start).
- **Stall combination**: `stall` = stall_rs ∨ stall_rt ∨ md_stall.
- **Stall outputs**: pc_en = fd_en = ¬stall; de_flush = stall. All three are purely combinational from the current inputs and `cnt`.
- **Busy counter** `cnt` (4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES)). Each edge, in priority order:
  - reset: 0.
  - else e_md_start ∧ cnt = 0: load DIV_CYCLES if e_md_div, else MULT_CYCLES.
  - else cnt ≠ 0: cnt − 1.
  - else: hold 0.
- **Start while busy**: `e_md_start` with cnt ≠ 0 is ignored and the counter keeps decrementing. The MD stall normally prevents this case.
- **md_busy**: equals (cnt ≠ 0).
- **Outputs while reset is high**: pc_en = 1, fd_en = 1, de_flush = 0, md_busy = 0. Hazard logic is masked; the pipeline registers reset themselves.

## Timing
- Stall decision has 0-cycle latency: inputs in cycle t produce pc_en/fd_en/de_flush in cycle t.
- Start at edge t: `e_md_start` is high during cycle t (md_stall already asserted in t if d_md_use).
- Busy window: md_busy is high in cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES) and low in t+N+1.
- Stall release: a D-stage HI/LO user held across the window sees pc_en = 1 first in cycle t+N+1.
- Reset mid-count: cnt = 0 after the reset edge; md_busy low the following cycle.
- Simultaneous reset and e_md_start: reset wins, no load.
- Data and MD stall in the same cycle: the outputs are identical; the stall is not counted twice.

## Configuration
- **`STALL_CTRL_MD_EN` defined**: counter, md_busy and md_stall behave as above.
- **`STALL_CTRL_MD_EN` undefined**:
  - The counter is not built and md_busy is tied to 0.
  - `d_md_use`, `e_md_start` and `e_md_div` are ignored.
  - stall = stall_rs ∨ stall_rt.
  - Ports remain present.

## Test plan
1. **Load-use stall from E**: e_wa=5, e_tnew=2, d_rs_addr=5, d_rs_tuse=1 -> pc_en=0, fd_en=0, de_flush=1. Changing to e_tnew=1 -> pc_en=1, de_flush=0.
2. **$0 and unused source**:
   - d_rs_addr=0, e_wa=0, e_tnew=2, d_rs_tuse=0 -> no stall.
   - d_rt_addr=7, e_wa=7, e_tnew=2, d_rt_tuse=3 -> no stall.
3. **Stall from M**: m_wa=8, m_tnew=1, d_rt_addr=8, d_rt_tuse=0 -> stall. With d_rt_tuse=1 -> no stall.
4. **Multiply window**: e_md_start=1, e_md_div=0 in cycle t, then d_md_use held 1 -> md_busy=1 in t+1..t+5. Required: de_flush=1 in t..t+5 and pc_en=1 in t+6. Divide variant releases at t+11.
5. **Reset mid-divide**: divide starts at t, reset=1 in t+3 -> md_busy=0 from t+4. With d_md_use=1 -> pc_en=1 in t+4.
6. **Macro undefined**: rerun scenario 4 -> md_busy=0 and pc_en=1 every cycle. Scenario 1 is unchanged.
